// File: rtl/uart_sched_pkg.sv
// ----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler:
//   state_t          - FSM encoding (IDLE = 0, WAIT = 1)
//   DATA_W           - byte width handed to the transmitter
//   MIN_FRAME_CYCLES - shortest legal frame (start + 8 data + stop)
//   ID_W             - width of a requester index (up to 8 requesters)
//   clog2()          - constant ceiling-log2 used to size the frame counter
// ----------------------------------------------------------------------------
package uart_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DATA_W           = 8;
    localparam int MIN_FRAME_CYCLES = 10;
    localparam int ID_W             = 3;

    // Ceiling log2 with a fixed iteration bound so it folds to a constant.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches i_req starting one position
// after i_ptr, wrapping around, and returns the first set bit.
// Ports:
//   i_req   [N_REQ]  pending request vector
//   i_ptr   [ID_W]   index of the most recently granted requester
//   o_valid          at least one request is pending
//   o_grant [N_REQ]  one-hot winner
//   o_idx   [ID_W]   binary index of the winner
// ----------------------------------------------------------------------------
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);

    // Walk the candidates in priority order (ptr+1, ptr+2, ...). The inner
    // loop keeps every bit select at a constant index.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!o_valid && i_req[i] && (((int'(i_ptr) + k) % N_REQ) == i)) begin
                    o_valid    = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
// Shares one byte-serial UART transmitter among N_REQ byte producers.
// In IDLE a pending requester is chosen round-robin, its byte is launched
// with a one-cycle o_uart_ready strobe and the requester gets a one-cycle
// o_grant_ack. The scheduler then sits in WAIT for the full frame (plus
// GAP_CYCLES of idle line) before arbitrating again.
//
// Optional feature macro: UART_SCHED_LOCK_EN
//   Adds i_req_lock. A grant taken with its lock bit set keeps that
//   requester first in line until it stops requesting or is granted
//   with the lock bit clear.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        [N_REQ]    byte pending per requester, held until ack
//   i_req_data   [8*N_REQ]  byte of requester i at [8*i+7:8*i]
//   i_req_lock   [N_REQ]    burst lock request (UART_SCHED_LOCK_EN only)
//   o_grant_ack  [N_REQ]    one-cycle accept pulse
//   o_grant_id   [3]        index of last granted requester
//   o_uart_data  [8]        byte to transmitter, valid with o_uart_ready
//   o_uart_ready            one-cycle launch strobe
//   o_busy                  frame in flight
// ----------------------------------------------------------------------------
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [DATA_W*N_REQ-1:0] i_req_data,
`ifdef UART_SCHED_LOCK_EN
    input  logic [N_REQ-1:0]        i_req_lock,
`endif
    output logic [N_REQ-1:0]        o_grant_ack,
    output logic [ID_W-1:0]         o_grant_id,
    output logic [DATA_W-1:0]       o_uart_data,
    output logic                    o_uart_ready,
    output logic                    o_busy
);

    // A frame shorter than start+8+stop cannot be honoured by the
    // transmitter, so shorter settings are clamped up.
    localparam int FRAME_EFF = (FRAME_CYCLES < MIN_FRAME_CYCLES) ? MIN_FRAME_CYCLES : FRAME_CYCLES;
    localparam int TOTAL     = FRAME_EFF + GAP_CYCLES;
    localparam int CNT_W     = clog2(TOTAL);
    // The grant edge itself and the edge returning to IDLE both belong to
    // the frame period, hence the -2.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 2);
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N_REQ - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic                r_uart_ready;
    logic                w_uart_ready_nxt;
    logic [DATA_W-1:0]   r_uart_data;
    logic [DATA_W-1:0]   w_uart_data_nxt;
    logic [N_REQ-1:0]    r_grant_ack;
    logic [N_REQ-1:0]    w_grant_ack_nxt;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     w_grant_id_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    logic                w_arb_valid;
    logic [N_REQ-1:0]    w_arb_grant;
    logic [ID_W-1:0]     w_arb_idx;

    logic                w_win_valid;
    logic [ID_W-1:0]     w_win_idx;
    logic [N_REQ-1:0]    w_win_onehot;
    logic [DATA_W-1:0]   w_win_data;

`ifdef UART_SCHED_LOCK_EN
    logic                r_lock_active;
    logic                w_lock_active_nxt;
    logic [ID_W-1:0]     r_lock_id;
    logic [ID_W-1:0]     w_lock_id_nxt;
    logic                w_lock_req;
    logic                w_win_lock;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_arb_valid),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // Winner selection: round-robin result, optionally overridden by an
    // active burst lock whose owner is still requesting.
    always_comb begin
        w_win_valid  = w_arb_valid;
        w_win_idx    = w_arb_idx;
        w_win_onehot = w_arb_grant;
`ifdef UART_SCHED_LOCK_EN
        w_lock_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(r_lock_id) == i) begin
                w_lock_req = i_req[i];
            end
        end
        if (r_lock_active && w_lock_req) begin
            w_win_valid  = 1'b1;
            w_win_idx    = r_lock_id;
            w_win_onehot = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (int'(r_lock_id) == i) begin
                    w_win_onehot[i] = 1'b1;
                end
            end
        end
        w_win_lock = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(w_win_idx) == i) begin
                w_win_lock = i_req_lock[i];
            end
        end
`endif
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(w_win_idx) == i) begin
                w_win_data = i_req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic. Strobes default low so they
    // only ever last a single cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ptr_nxt        = r_ptr;
        w_uart_ready_nxt = 1'b0;
        w_uart_data_nxt  = r_uart_data;
        w_grant_ack_nxt  = '0;
        w_grant_id_nxt   = r_grant_id;
        w_busy_nxt       = r_busy;
`ifdef UART_SCHED_LOCK_EN
        w_lock_active_nxt = r_lock_active;
        w_lock_id_nxt     = r_lock_id;
`endif
        case (r_state)
            IDLE: begin
`ifdef UART_SCHED_LOCK_EN
                // Lock owner stopped requesting: release the lock.
                if (r_lock_active && !w_lock_req) begin
                    w_lock_active_nxt = 1'b0;
                end
`endif
                if (w_win_valid) begin
                    w_uart_data_nxt  = w_win_data;
                    w_uart_ready_nxt = 1'b1;
                    w_grant_ack_nxt  = w_win_onehot;
                    w_grant_id_nxt   = w_win_idx;
                    w_ptr_nxt        = w_win_idx;
                    w_cnt_nxt        = '0;
                    w_busy_nxt       = 1'b1;
                    w_state_nxt      = WAIT;
`ifdef UART_SCHED_LOCK_EN
                    w_lock_active_nxt = w_win_lock;
                    w_lock_id_nxt     = w_win_idx;
`endif
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers. The pointer resets to the last requester
    // so requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ptr        <= PTR_INIT;
            r_uart_ready <= 1'b0;
            r_uart_data  <= '0;
            r_grant_ack  <= '0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
`ifdef UART_SCHED_LOCK_EN
            r_lock_active <= 1'b0;
            r_lock_id     <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_uart_ready <= w_uart_ready_nxt;
            r_uart_data  <= w_uart_data_nxt;
            r_grant_ack  <= w_grant_ack_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_busy       <= w_busy_nxt;
`ifdef UART_SCHED_LOCK_EN
            r_lock_active <= w_lock_active_nxt;
            r_lock_id     <= w_lock_id_nxt;
`endif
        end
    end

    assign o_grant_ack  = r_grant_ack;
    assign o_grant_id   = r_grant_id;
    assign o_uart_data  = r_uart_data;
    assign o_uart_ready = r_uart_ready;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched. dutA runs with a 10-cycle frame and
// no gap, dutB adds a 3-cycle gap. dutA launches are checked against a
// scoreboard queue of expected (requester, byte) pairs. Honours
// UART_SCHED_LOCK_EN when defined.
// ----------------------------------------------------------------------------
module tb_uart_tx_sched;

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [3:0]  reqA;
    logic [31:0] dataA;
    logic [3:0]  lockA;
    logic [3:0]  ackA;
    logic [2:0]  idA;
    logic [7:0]  udataA;
    logic        readyA;
    logic        busyA;

    logic [3:0]  reqB;
    logic [31:0] dataB;
    logic [3:0]  lockB;
    logic [3:0]  ackB;
    logic [2:0]  idB;
    logic [7:0]  udataB;
    logic        readyB;
    logic        busyB;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pushCnt  = 0;
    int   pulseCntA = 0;
    exp_t expQ[$];
    exp_t monE;

    uart_tx_sched #(.N_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(0)) dutA (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (reqA),
        .i_req_data   (dataA),
`ifdef UART_SCHED_LOCK_EN
        .i_req_lock   (lockA),
`endif
        .o_grant_ack  (ackA),
        .o_grant_id   (idA),
        .o_uart_data  (udataA),
        .o_uart_ready (readyA),
        .o_busy       (busyA)
    );

    uart_tx_sched #(.N_REQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(3)) dutB (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (reqB),
        .i_req_data   (dataB),
`ifdef UART_SCHED_LOCK_EN
        .i_req_lock   (lockB),
`endif
        .o_grant_ack  (ackB),
        .o_grant_id   (idB),
        .o_uart_data  (udataB),
        .o_uart_ready (readyB),
        .o_busy       (busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor for dutA: every launch must match the oldest
    // expectation, and no acknowledge may appear without a launch.
    always @(negedge clk) begin
        if (readyA === 1'b1) begin
            pulseCntA++;
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_unexpected got id=%0d data=%h, expected no launch", idA, udataA);
            end else begin
                monE = expQ.pop_front();
                if (idA !== monE.id || udataA !== monE.data || ackA !== (4'b0001 << monE.id)) begin
                    failures++;
                    $display("[TB] FAIL sb_launch got id=%0d data=%h ack=%b, expected id=%0d data=%h ack=%b",
                             idA, udataA, ackA, monE.id, monE.data, 4'b0001 << monE.id);
                end
            end
        end else if (ackA !== 4'b0000) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray_ack got ack=%b, expected 0000 without uart_ready", ackA);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input logic [2:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        expQ.push_back(e);
        pushCnt++;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitPulseA(input int budget, input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (readyA === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s_timeout got no uart_ready in %0d cycles, expected a launch", tag, budget);
    endtask

    task automatic waitPulseB(input int budget, input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (readyB === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s_timeout got no uart_ready in %0d cycles, expected a launch", tag, budget);
    endtask

    task automatic waitIdleA(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busyA === 1'b0) return;
        end
        checks++;
        failures++;
        $display("[TB] FAIL idle_timeout got busy=%b, expected 0 within %0d cycles", busyA, budget);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqA = '0; dataA = '0; lockA = '0;
        reqB = '0; dataB = '0; lockB = '0;
        @(negedge clk);
        checks++; if (readyA !== 1'b0)  begin failures++; $display("[TB] FAIL rst_ready got %b, expected 0", readyA); end
        checks++; if (busyA !== 1'b0)   begin failures++; $display("[TB] FAIL rst_busy got %b, expected 0", busyA); end
        checks++; if (ackA !== 4'b0)    begin failures++; $display("[TB] FAIL rst_ack got %b, expected 0000", ackA); end
        checks++; if (idA !== 3'd0)     begin failures++; $display("[TB] FAIL rst_id got %0d, expected 0", idA); end
        checks++; if (udataA !== 8'h00) begin failures++; $display("[TB] FAIL rst_data got %h, expected 00", udataA); end
        checks++; if (readyB !== 1'b0 || busyB !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_dutB got ready=%b busy=%b, expected 0 0", readyB, busyB);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int busyCycles;
        logic [9:0] line;
        dataA = 32'h0000_00A5;
        pushExp(3'd0, 8'hA5);
        reqA = 4'b0001;
        waitPulseA(10, "single", ok);
        if (!ok) return;
        reqA = 4'b0000;
        // Transmitter line order: start, data LSB first, stop.
        line = {1'b1, udataA, 1'b0};
        checks++;
        if (line !== 10'b11_0100_1010) begin
            failures++;
            $display("[TB] FAIL single_line got %b, expected 1101001010", line);
        end
        busyCycles = (busyA === 1'b1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busyA !== 1'b1) break;
            busyCycles++;
        end
        checks++;
        if (busyCycles != 9) begin
            failures++;
            $display("[TB] FAIL single_busy got %0d cycles, expected 9", busyCycles);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int t[5];
        applyReset();
        dataA = 32'h4433_2211;
        pushExp(3'd0, 8'h11);
        pushExp(3'd1, 8'h22);
        pushExp(3'd2, 8'h33);
        pushExp(3'd3, 8'h44);
        pushExp(3'd0, 8'h11);
        reqA = 4'b1111;
        for (int p = 0; p < 5; p++) begin
            waitPulseA(30, "rr", ok);
            if (!ok) begin
                reqA = '0;
                return;
            end
            t[p] = cyc;
        end
        reqA = 4'b0000;
        for (int p = 1; p < 5; p++) begin
            checks++;
            if (t[p] - t[p-1] != 10) begin
                failures++;
                $display("[TB] FAIL rr_spacing%0d got %0d cycles, expected 10", p, t[p] - t[p-1]);
            end
        end
        waitIdleA(20);
    endtask

    task automatic test_mid_reset();
        bit ok;
        dataA = 32'h005A_0000;
        pushExp(3'd2, 8'h5A);
        reqA = 4'b0100;
        waitPulseA(20, "midrst", ok);
        reqA = 4'b0000;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (readyA !== 1'b0 || busyA !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_async got ready=%b busy=%b, expected 0 0", readyA, busyA);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Pointer was left at 2; after reset requester 0 must win again.
        dataA = 32'hD3C2_B1A0;
        pushExp(3'd0, 8'hA0);
        reqA = 4'b1111;
        waitPulseA(10, "midrst_first", ok);
        reqA = 4'b0000;
        if (ok) begin
            checks++;
            if (idA !== 3'd0) begin
                failures++;
                $display("[TB] FAIL midrst_first got id=%0d, expected 0", idA);
            end
        end
        waitIdleA(20);
    endtask

    task automatic test_gap();
        bit ok;
        int t[4];
        logic [2:0] expId[4];
        logic [7:0] expData[4];
        expId   = '{3'd0, 3'd0, 3'd0, 3'd1};
        expData = '{8'hB1, 8'hB1, 8'hB1, 8'hB2};
        dataB = 32'h0000_B2B1;
        reqB  = 4'b0001;
        for (int p = 0; p < 4; p++) begin
            waitPulseB(30, "gap", ok);
            if (!ok) begin
                reqB = '0;
                return;
            end
            t[p] = cyc;
            checks++;
            if (idB !== expId[p] || udataB !== expData[p] || ackB !== (4'b0001 << expId[p])) begin
                failures++;
                $display("[TB] FAIL gap_launch%0d got id=%0d data=%h ack=%b, expected id=%0d data=%h",
                         p, idB, udataB, ackB, expId[p], expData[p]);
            end
            if (p == 2) begin
                // Raise requester 1 while the frame is still in flight.
                @(negedge clk);
                @(negedge clk);
                reqB = 4'b0011;
            end
        end
        reqB = 4'b0000;
        for (int p = 1; p < 4; p++) begin
            checks++;
            if (t[p] - t[p-1] != 13) begin
                failures++;
                $display("[TB] FAIL gap_spacing%0d got %0d cycles, expected 13", p, t[p] - t[p-1]);
            end
        end
    endtask

    task automatic test_lock_or_alternate();
        bit ok;
        int n0;
        int n1;
        logic [7:0] bytes0[3];
        logic [7:0] bytes1[2];
        bytes0 = '{8'hC0, 8'hC1, 8'hC2};
        bytes1 = '{8'hD0, 8'hD1};
        applyReset();
        n0 = 0;
        n1 = 0;
`ifdef UART_SCHED_LOCK_EN
        pushExp(3'd0, 8'hC0);
        pushExp(3'd0, 8'hC1);
        pushExp(3'd0, 8'hC2);
        pushExp(3'd1, 8'hD0);
        pushExp(3'd1, 8'hD1);
        lockA = 4'b0001;
`else
        pushExp(3'd0, 8'hC0);
        pushExp(3'd1, 8'hD0);
        pushExp(3'd0, 8'hC1);
        pushExp(3'd1, 8'hD1);
        pushExp(3'd0, 8'hC2);
        lockA = 4'b0000;
`endif
        dataA = {16'h0000, bytes1[0], bytes0[0]};
        reqA  = 4'b0011;
        for (int p = 0; p < 5; p++) begin
            waitPulseA(40, "burst", ok);
            if (!ok) break;
            // Requesters react to their acknowledge: next byte or drop.
            if (ackA[0] === 1'b1) begin
                n0++;
                if (n0 < 3) dataA[7:0] = bytes0[n0];
                else begin
                    reqA[0]  = 1'b0;
                    lockA[0] = 1'b0;
                end
            end
            if (ackA[1] === 1'b1) begin
                n1++;
                if (n1 < 2) dataA[15:8] = bytes1[n1];
                else reqA[1] = 1'b0;
            end
        end
        reqA  = 4'b0000;
        lockA = 4'b0000;
        waitIdleA(20);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t0;
        int tDrop;
        int t1;
        dataA = 32'h8877_0000;
        pushExp(3'd2, 8'h77);
        reqA = 4'b0100;
        waitPulseA(20, "b2b_first", ok);
        reqA = 4'b0000;
        if (!ok) return;
        t0 = cyc;
        waitIdleA(20);
        tDrop = cyc;
        pushExp(3'd3, 8'h88);
        reqA = 4'b1000;
        waitPulseA(5, "b2b_second", ok);
        reqA = 4'b0000;
        if (!ok) return;
        t1 = cyc;
        checks++;
        if (t1 - tDrop != 1) begin
            failures++;
            $display("[TB] FAIL b2b_latency got %0d cycles, expected 1", t1 - tDrop);
        end
        checks++;
        if (t1 - t0 != 10) begin
            failures++;
            $display("[TB] FAIL b2b_spacing got %0d cycles, expected 10", t1 - t0);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL sb_leftover got %0d pending, expected 0", expQ.size());
        end
        checks++;
        if (pulseCntA != pushCnt) begin
            failures++;
            $display("[TB] FAIL sb_count got %0d launches, expected %0d", pulseCntA, pushCnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mid_reset();
        test_gap();
        test_lock_or_alternate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
